pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register; the next generation of the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W payload with valid/ready handshake and a 2-entry skid buffer, so back-pressure does not create a combinational ready path across stages.
- Adds synchronous flush (bubble insertion) and a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stage_skid.sv | 82 ++++++++
 tb/tb_pipe_stage_skid.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state type, width constants and per-boundary payload structs
package pipe_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} pipe_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            alu_op;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  reg_wr;
  } id_ex_t;
  typedef struct packed {
    logic [XLEN-1:0]       alu_res;
    logic [XLEN-1:0]       store_val;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  reg_wr;
  } ex_mem_t;
  typedef struct packed {
    logic [XLEN-1:0]       wb_val;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
  } mem_wb_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear priority
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins; otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  end
  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush and stall counter
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter bit CLEAR_ON_FLUSH = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_cnt_clr_i
);
  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept, drain;
  assign valid_o = state_q != EMPTY;
  assign ready_o = state_q != FULL;
  assign data_o  = main_data_q;
  assign accept  = valid_i & ready_o;
  assign drain   = valid_o & ready_i;
  // next state and data moves; flush overrides any accept or drain
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_data_d = data_i;
          state_d     = ONE;
        end
        ONE: if (accept && drain) begin
          main_data_d = data_i;
        end else if (accept) begin
          skid_data_d = data_i;
          state_d     = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
        FULL: if (drain) begin
          main_data_d = skid_data_q;
          state_d     = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // state and data registers, all cleared by reset so data_o is never X
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (valid_o & ~ready_i),
    .clr_i (stall_cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: random and directed checks of two stage configurations against a queue model
module tb_pipe_stage_skid;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, valid_i = 1'b0, ready_i = 1'b1, clr = 1'b0;
  logic [31:0] data_i = '0;
  logic        va, ra, vb, rb;
  logic [31:0] da, db;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int          total = 0, bad = 0;
  logic [31:0] q[$];
  int          ca = 0, cb = 0;
  bit          acc_last = 1'b0;

  pipe_stage_skid dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(ra),
    .data_i(data_i), .valid_o(va), .ready_i(ready_i), .data_o(da),
    .stall_cnt_o(cnt_a), .stall_cnt_clr_i(clr)
  );
  pipe_stage_skid #(.DATA_W(32), .CNT_W(4), .CLEAR_ON_FLUSH(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(rb),
    .data_i(data_i), .valid_o(vb), .ready_i(ready_i), .data_o(db),
    .stall_cnt_o(cnt_b), .stall_cnt_clr_i(clr)
  );

  always #5 clk = ~clk;

  // reference: a FIFO of at most two entries plus saturating stall counts
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      ca = 0;
      cb = 0;
      acc_last = 1'b0;
    end else begin
      automatic bit v = q.size() > 0;
      automatic bit r = q.size() < 2;
      if (clr) begin
        ca = 0;
        cb = 0;
      end else if (v && !ready_i) begin
        if (ca < 65535) ca++;
        if (cb < 15) cb++;
      end
      if (flush) q.delete();
      else begin
        if (v && ready_i) void'(q.pop_front());
        if (valid_i && r) q.push_back(data_i);
      end
      acc_last = valid_i && r;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("a_valid", va, q.size() > 0);
    chk("b_valid", vb, q.size() > 0);
    chk("a_ready", ra, q.size() < 2);
    chk("b_ready", rb, q.size() < 2);
    if (q.size() > 0) begin
      chk("a_data", da, q[0]);
      chk("b_data", db, q[0]);
    end
    chk("a_cnt", cnt_a, ca);
    chk("b_cnt", cnt_b, cb);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk_all();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", va, 0);
    chk("rst_data", da, 0);
    chk("rst_ready", ra, 1);
    chk("rst_cnt", cnt_a, 0);
    rst = 1'b0;
    // reset while FULL
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 32'hA; tick();
    data_i = 32'hB; tick();
    valid_i = 1'b0;
    chk("full_ready", ra, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid_a", va, 0);
    chk("mid_rst_valid_b", vb, 0);
    chk("mid_rst_data_a", da, 0);
    chk("mid_rst_data_b", db, 0);
    chk("mid_rst_ready", ra, 1);
    chk("mid_rst_cnt_a", cnt_a, 0);
    chk("mid_rst_cnt_b", cnt_b, 0);
    #1 rst = 1'b0;
    valid_i = 1'b1; data_i = 32'hC; ready_i = 1'b1; tick();
    valid_i = 1'b0;
    chk("post_rst_valid", va, 1);
    chk("post_rst_data", da, 32'hC);
    // back-to-back streaming
    for (int i = 1; i <= 100; i++) begin
      valid_i = 1'b1; data_i = i; ready_i = 1'b1; tick();
      chk("stream_data", da, i);
      chk("stream_ready", ra, 1);
      chk("stream_cnt", cnt_a, 0);
    end
    valid_i = 1'b0; tick();
    // skid fill and drain
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 32'h11; tick();
    data_i = 32'h22; tick();
    valid_i = 1'b0;
    chk("skid_ready", ra, 0);
    chk("skid_head", da, 32'h11);
    ready_i = 1'b1; tick();
    chk("skid_second", da, 32'h22);
    chk("skid_ready_back", ra, 1);
    tick();
    chk("skid_empty", va, 0);
    // flush while FULL with a concurrent offer
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 32'h11; tick();
    data_i = 32'h22; tick();
    flush = 1'b1; data_i = 32'h33; tick();
    flush = 1'b0; valid_i = 1'b0;
    chk("flush_valid_a", va, 0);
    chk("flush_valid_b", vb, 0);
    chk("flush_keep_a", da, 32'h11);
    chk("flush_clear_b", db, 0);
    ready_i = 1'b1; tick();
    chk("flush_no_33", va, 0);
    // counter saturation and clear priority
    clr = 1'b1; tick();
    clr = 1'b0;
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h44; tick();
    valid_i = 1'b0;
    repeat (20) tick();
    chk("sat_b", cnt_b, 15);
    chk("sat_a", cnt_a, 20);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("clr_b", cnt_b, 0);
    chk("clr_a", cnt_a, 0);
    // randomized traffic honouring the upstream hold rule
    for (int i = 0; i < 10000; i++) begin
      if (!(valid_i && !acc_last)) begin
        valid_i = $urandom_range(0, 3) != 0;
        data_i = $urandom;
      end
      ready_i = $urandom_range(0, 9) < (((i / 500) % 2) ? 8 : 3);
      flush = $urandom_range(0, 31) == 0;
      clr = $urandom_range(0, 63) == 0;
      tick();
    end
    valid_i = 1'b0; flush = 1'b0; clr = 1'b0; ready_i = 1'b1;
    repeat (3) tick();
    chk("final_empty", va, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
